// File: rtl/tictactoe_pkg.sv
// rtl/tictactoe_pkg.sv - shared cell/state types, board constants and win-line table
package tictactoe_pkg;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_P1    = 2'b01,
        CELL_P2    = 2'b10
    } cell_e;

    typedef enum logic [2:0] {
        ST_PLAY   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_WIN_P1 = 3'd2,
        ST_WIN_P2 = 3'd3,
        ST_DRAW   = 3'd4
    } state_e;

    localparam int NUM_CELLS = 9;
    localparam int NUM_LINES = 8;
    localparam int BOARD_W   = 2 * NUM_CELLS;

    typedef logic [3:0] cell_idx_t;

    // Cell triples in win_line bit order: rows, columns, diagonal, anti-diagonal
    localparam cell_idx_t WIN_LINES [NUM_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    // Decoded read of one cell; out-of-range indices read as empty
    function automatic cell_e cell_at(input logic [BOARD_W-1:0] brd, input cell_idx_t idx);
        cell_e c = CELL_EMPTY;
        for (int k = 0; k < NUM_CELLS; k++) begin
            if (idx == cell_idx_t'(k)) begin
                c = cell_e'(brd[2*k +: 2]);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/tictactoe_board_if.sv
// rtl/tictactoe_board_if.sv - controller <-> board keeper move/result bundle
interface tictactoe_board_if;
    import tictactoe_pkg::*;

    logic                 new_game;
    logic                 move_p1_vld;
    logic [3:0]           move_p1;
    logic                 move_p2_vld;
    logic [3:0]           move_p2;
    logic                 illegal_move;
    logic [BOARD_W-1:0]   board;
    logic [3:0]           move_cnt;
    logic                 game_over;
    logic [1:0]           winner;
    logic [NUM_LINES-1:0] win_line;

    modport master (
        output new_game, move_p1_vld, move_p1, move_p2_vld, move_p2,
        input  illegal_move, board, move_cnt, game_over, winner, win_line
    );

    modport slave (
        input  new_game, move_p1_vld, move_p1, move_p2_vld, move_p2,
        output illegal_move, board, move_cnt, game_over, winner, win_line
    );
endinterface

// File: rtl/tictactoe_win_detect.sv
// rtl/tictactoe_win_detect.sv - combinational three-in-a-row detector over the 8 lines
module tictactoe_win_detect
    import tictactoe_pkg::*;
(
    input  logic [BOARD_W-1:0]   board,
    output logic                 p1_win,
    output logic                 p2_win,
    output logic [NUM_LINES-1:0] line_mask
);

    // A line is complete when its three cells hold the same non-empty code
    always_comb begin
        p1_win    = 1'b0;
        p2_win    = 1'b0;
        line_mask = '0;
        for (int l = 0; l < NUM_LINES; l++) begin
            if (cell_at(board, WIN_LINES[l][0]) != CELL_EMPTY &&
                cell_at(board, WIN_LINES[l][0]) == cell_at(board, WIN_LINES[l][1]) &&
                cell_at(board, WIN_LINES[l][1]) == cell_at(board, WIN_LINES[l][2])) begin
                line_mask[l] = 1'b1;
                if (cell_at(board, WIN_LINES[l][0]) == CELL_P1) begin
                    p1_win = 1'b1;
                end else begin
                    p2_win = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tictactoe_board.sv
// rtl/tictactoe_board.sv - board keeper: move validation, win/draw FSM, auto-clear; turn check under TTT_TURN_CHECK_EN
module tictactoe_board
    import tictactoe_pkg::*;
#(
    parameter bit FIRST_PLAYER      = 1'b1,
    parameter int AUTO_CLEAR_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    tictactoe_board_if.slave bus
);

    localparam int ACW = (AUTO_CLEAR_CYCLES > 1) ? $clog2(AUTO_CLEAR_CYCLES) : 1;
    localparam logic [ACW-1:0] AC_LOAD = (AUTO_CLEAR_CYCLES > 0) ? ACW'(AUTO_CLEAR_CYCLES - 1) : '0;

    logic                 ng_q;
    logic                 p1_vld_q;
    logic                 p2_vld_q;
    cell_idx_t            p1_idx_q;
    cell_idx_t            p2_idx_q;

    state_e               state_q, state_d;
    logic [BOARD_W-1:0]   board_q, board_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 illegal_q, illegal_d;
    logic [ACW-1:0]       ac_q, ac_d;

    logic                 both_vld;
    logic                 move_req;
    logic                 mover_p1;
    cell_idx_t            idx;
    logic                 in_range;
    logic                 occupied;
    logic                 turn_ok;
    logic                 move_ok;
    logic                 accept;
    logic                 end_state;
    logic                 auto_clear;
    logic                 clear;

    logic                 p1_win;
    logic                 p2_win;
    logic [NUM_LINES-1:0] line_mask;
    logic [NUM_LINES-1:0] first_line;
    logic [1:0]           winner_w;

    // Sample the controller's strobes so every decision sees stable inputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ng_q     <= 1'b0;
            p1_vld_q <= 1'b0;
            p2_vld_q <= 1'b0;
            p1_idx_q <= '0;
            p2_idx_q <= '0;
        end else begin
            ng_q     <= bus.new_game;
            p1_vld_q <= bus.move_p1_vld;
            p2_vld_q <= bus.move_p2_vld;
            p1_idx_q <= bus.move_p1;
            p2_idx_q <= bus.move_p2;
        end
    end

    // Classify the sampled move: who moves, where, and whether the cell can take it
    always_comb begin
        both_vld = p1_vld_q & p2_vld_q;
        move_req = p1_vld_q | p2_vld_q;
        mover_p1 = ~p2_vld_q;
        idx      = p2_vld_q ? p2_idx_q : p1_idx_q;
        in_range = idx < cell_idx_t'(NUM_CELLS);
        occupied = cell_at(board_q, idx) != CELL_EMPTY;
        move_ok  = move_req & ~both_vld & in_range & ~occupied & turn_ok;
    end

    assign end_state  = (state_q == ST_WIN_P1) || (state_q == ST_WIN_P2) || (state_q == ST_DRAW);
    assign auto_clear = (AUTO_CLEAR_CYCLES != 0) && end_state && (ac_q == '0);
    assign clear      = ng_q | auto_clear;
    assign accept     = (state_q == ST_PLAY) & move_ok & ~clear;

`ifdef TTT_TURN_CHECK_EN
    logic turn_p1_q;

    // Whose turn it is; flips only when a move is actually written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            turn_p1_q <= FIRST_PLAYER;
        end else if (clear) begin
            turn_p1_q <= FIRST_PLAYER;
        end else if (accept) begin
            turn_p1_q <= ~turn_p1_q;
        end
    end

    assign turn_ok = (mover_p1 == turn_p1_q);
`else
    logic unused_first_player;

    assign unused_first_player = FIRST_PLAYER;
    assign turn_ok             = 1'b1;
`endif

    tictactoe_win_detect u_win_detect (
        .board     (board_q),
        .p1_win    (p1_win),
        .p2_win    (p2_win),
        .line_mask (line_mask)
    );

    // Game state, board contents and the registered illegal pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_PLAY;
            board_q   <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            ac_q      <= '0;
        end else begin
            state_q   <= state_d;
            board_q   <= board_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            ac_q      <= ac_d;
        end
    end

    // Next state: new_game/auto-clear first, then move handling and the one-cycle CHECK
    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        cnt_d     = cnt_q;
        illegal_d = 1'b0;
        ac_d      = ac_q;
        if (clear) begin
            state_d = ST_PLAY;
            board_d = '0;
            cnt_d   = '0;
            ac_d    = '0;
        end else begin
            unique case (state_q)
                ST_PLAY: begin
                    if (accept) begin
                        for (int k = 0; k < NUM_CELLS; k++) begin
                            if (idx == cell_idx_t'(k)) begin
                                board_d[2*k +: 2] = mover_p1 ? CELL_P1 : CELL_P2;
                            end
                        end
                        cnt_d   = cnt_q + 4'd1;
                        state_d = ST_CHECK;
                    end else if (move_req) begin
                        illegal_d = 1'b1;
                    end
                end
                ST_CHECK: begin
                    illegal_d = move_req;
                    ac_d      = AC_LOAD;
                    if (p1_win) begin
                        state_d = ST_WIN_P1;
                    end else if (p2_win) begin
                        state_d = ST_WIN_P2;
                    end else if (cnt_q == 4'(NUM_CELLS)) begin
                        state_d = ST_DRAW;
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
                ST_WIN_P1, ST_WIN_P2, ST_DRAW: begin
                    illegal_d = move_req;
                    if (ac_q != '0) begin
                        ac_d = ac_q - ACW'(1);
                    end
                end
                default: begin
                    state_d = ST_PLAY;
                end
            endcase
        end
    end

    // Two lines can close on one move; report only the lowest-numbered one
    assign first_line = line_mask & (~line_mask + NUM_LINES'(1));

    // Result code derived from the end state
    always_comb begin
        winner_w = 2'b00;
        case (state_q)
            ST_WIN_P1: winner_w = 2'b01;
            ST_WIN_P2: winner_w = 2'b10;
            ST_DRAW:   winner_w = 2'b11;
            default:   winner_w = 2'b00;
        endcase
    end

    assign bus.illegal_move = illegal_q;
    assign bus.board        = board_q;
    assign bus.move_cnt     = cnt_q;
    assign bus.game_over    = end_state;
    assign bus.winner       = winner_w;
    assign bus.win_line     = ((state_q == ST_WIN_P1) || (state_q == ST_WIN_P2)) ? first_line : '0;

endmodule

// File: tb/tb_tictactoe_board.sv
// tb/tb_tictactoe_board.sv - randomized self-checking bench with a behavioural board model
module tb_tictactoe_board;

    localparam int AC = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    tictactoe_board_if ttt_if ();

    tictactoe_board #(
        .FIRST_PLAYER      (1'b1),
        .AUTO_CLEAR_CYCLES (AC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ttt_if)
    );

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // model state: cells 0=empty 1=P1 2=P2; phase 0=play 1=check 2=end
    int m_cell [9];
    int m_cnt;
    int m_phase;
    int m_res;
    int m_line;
    bit m_ill;
    bit m_turn_p1;
    int m_ac;
    bit pend_ng, pend_v1, pend_v2;
    int pend_i1, pend_i2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int line_cell(input int l, input int j);
        if (l < 3)       return 3 * l + j;
        else if (l < 6)  return (l - 3) + 3 * j;
        else if (l == 6) return 4 * j;
        else             return 2 + 2 * j;
    endfunction

    task automatic m_clear();
        for (int k = 0; k < 9; k++) m_cell[k] = 0;
        m_cnt     = 0;
        m_phase   = 0;
        m_res     = 0;
        m_line    = 0;
        m_ill     = 1'b0;
        m_turn_p1 = 1'b1;
        m_ac      = 0;
    endtask

    task automatic m_step();
        int  who;
        int  idx;
        bit  ok;
        bit  mv;
        int  wl;
        mv = pend_v1 || pend_v2;
        if (pend_ng || (AC != 0 && m_phase == 2 && m_ac == 0)) begin
            m_clear();
        end else begin
            m_ill = 1'b0;
            if (m_phase == 0) begin
                if (mv) begin
                    who = pend_v2 ? 2 : 1;
                    idx = pend_v2 ? pend_i2 : pend_i1;
                    ok  = !(pend_v1 && pend_v2) && (idx < 9);
                    if (ok) ok = (m_cell[idx] == 0);
`ifdef TTT_TURN_CHECK_EN
                    if (ok) ok = (who == (m_turn_p1 ? 1 : 2));
`endif
                    if (ok) begin
                        m_cell[idx] = who;
                        m_cnt++;
                        m_phase   = 1;
                        m_turn_p1 = !m_turn_p1;
                    end else begin
                        m_ill = 1'b1;
                    end
                end
            end else if (m_phase == 1) begin
                m_ill = mv;
                wl = -1;
                for (int l = 7; l >= 0; l--) begin
                    if (m_cell[line_cell(l, 0)] != 0 &&
                        m_cell[line_cell(l, 0)] == m_cell[line_cell(l, 1)] &&
                        m_cell[line_cell(l, 1)] == m_cell[line_cell(l, 2)]) wl = l;
                end
                m_ac = AC - 1;
                if (wl >= 0) begin
                    m_phase = 2;
                    m_res   = m_cell[line_cell(wl, 0)];
                    m_line  = wl;
                end else if (m_cnt == 9) begin
                    m_phase = 2;
                    m_res   = 3;
                end else begin
                    m_phase = 0;
                end
            end else begin
                m_ill = mv;
                if (m_ac > 0) m_ac--;
            end
        end
    endtask

    // reference model: applies what was sampled at the previous edge
    initial begin
        m_clear();
        pend_ng = 0; pend_v1 = 0; pend_v2 = 0; pend_i1 = 0; pend_i2 = 0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_clear();
                pend_ng = 0; pend_v1 = 0; pend_v2 = 0;
            end else begin
                m_step();
                pend_ng = ttt_if.new_game;
                pend_v1 = ttt_if.move_p1_vld;
                pend_v2 = ttt_if.move_p2_vld;
                pend_i1 = int'(ttt_if.move_p1);
                pend_i2 = int'(ttt_if.move_p2);
            end
        end
    end

    // per-cycle compare against the model
    initial begin
        logic [17:0] eb;
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                for (int k = 0; k < 9; k++) eb[2*k +: 2] = 2'(m_cell[k]);
                chk("board",        32'(ttt_if.board),        32'(eb));
                chk("move_cnt",     32'(ttt_if.move_cnt),     32'(m_cnt));
                chk("illegal_move", 32'(ttt_if.illegal_move), 32'(m_ill));
                chk("game_over",    32'(ttt_if.game_over),    32'(m_phase == 2));
                chk("winner",       32'(ttt_if.winner),       (m_phase == 2) ? 32'(m_res) : 32'd0);
                chk("win_line",     32'(ttt_if.win_line),
                    (m_phase == 2 && m_res != 3) ? (32'd1 << m_line) : 32'd0);
            end
        end
    end

    task automatic drive(input bit v1, input int i1, input bit v2, input int i2, input bit ng);
        ttt_if.move_p1_vld = v1;
        ttt_if.move_p1     = 4'(i1);
        ttt_if.move_p2_vld = v2;
        ttt_if.move_p2     = 4'(i2);
        ttt_if.new_game    = ng;
    endtask

    task automatic strobe(input bit v1, input int i1, input bit v2, input int i2, input bit ng);
        @(posedge clk); #1;
        drive(v1, i1, v2, i2, ng);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int draw_seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

    initial begin
        int r, p2, ix, ix2;
        drive(0, 0, 0, 0, 0);
        #2 reset = 1'b1;
        cmp_en = 1'b1;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;

        settle(1);
        chk("lit_reset_board", 32'(ttt_if.board), 32'd0);
        chk("lit_reset_cnt",   32'(ttt_if.move_cnt), 32'd0);
        chk("lit_reset_over",  32'(ttt_if.game_over), 32'd0);
        chk("lit_reset_win",   32'(ttt_if.winner), 32'd0);

        // P1 wins top row
        strobe(1, 0, 0, 0, 0); gap(3);
        strobe(0, 0, 1, 3, 0); gap(3);
        strobe(1, 1, 0, 0, 0); gap(3);
        strobe(0, 0, 1, 4, 0); gap(3);
        strobe(1, 2, 0, 0, 0);
        settle(2);
        chk("lit_win_board",  32'(ttt_if.board), 32'h295);
        chk("lit_win_cnt",    32'(ttt_if.move_cnt), 32'd5);
        chk("lit_win_check",  32'(ttt_if.game_over), 32'd0);
        settle(1);
        chk("lit_win_over",   32'(ttt_if.game_over), 32'd1);
        chk("lit_win_winner", 32'(ttt_if.winner), 32'd1);
        chk("lit_win_line",   32'(ttt_if.win_line), 32'h01);
        settle(3);
        chk("lit_ac_hold",    32'(ttt_if.game_over), 32'd1);
        settle(1);
        chk("lit_ac_over",    32'(ttt_if.game_over), 32'd0);
        chk("lit_ac_board",   32'(ttt_if.board), 32'd0);

        // occupied cell
        strobe(1, 4, 0, 0, 0); gap(3);
        strobe(0, 0, 1, 4, 0);
        settle(2);
        chk("lit_occ_ill",   32'(ttt_if.illegal_move), 32'd1);
        chk("lit_occ_board", 32'(ttt_if.board), 32'h100);
        chk("lit_occ_cnt",   32'(ttt_if.move_cnt), 32'd1);
        settle(1);
        chk("lit_occ_pulse", 32'(ttt_if.illegal_move), 32'd0);

        // out-of-range indices
        strobe(0, 0, 0, 0, 1); gap(2);
        strobe(1, 9, 0, 0, 0);
        strobe(1, 15, 0, 0, 0);
        settle(2);
        chk("lit_rng_ill",   32'(ttt_if.illegal_move), 32'd1);
        chk("lit_rng_board", 32'(ttt_if.board), 32'd0);

        // full draw
        strobe(0, 0, 0, 0, 1); gap(2);
        for (int i = 0; i < 9; i++) begin
            if (i % 2 == 0) strobe(1, draw_seq[i], 0, 0, 0);
            else            strobe(0, 0, 1, draw_seq[i], 0);
            if (i != 8) gap(3);
        end
        settle(3);
        chk("lit_draw_winner", 32'(ttt_if.winner), 32'd3);
        chk("lit_draw_cnt",    32'(ttt_if.move_cnt), 32'd9);
        chk("lit_draw_line",   32'(ttt_if.win_line), 32'd0);
        gap(6);

        // both strobes, then new_game with a strobe
        strobe(1, 0, 1, 1, 0);
        settle(2);
        chk("lit_both_ill",   32'(ttt_if.illegal_move), 32'd1);
        chk("lit_both_board", 32'(ttt_if.board), 32'd0);
        strobe(1, 5, 0, 0, 1);
        settle(2);
        chk("lit_ng_ill",   32'(ttt_if.illegal_move), 32'd0);
        chk("lit_ng_board", 32'(ttt_if.board), 32'd0);

`ifdef TTT_TURN_CHECK_EN
        strobe(1, 0, 0, 0, 0); gap(3);
        strobe(1, 1, 0, 0, 0);
        settle(2);
        chk("lit_turn_ill",   32'(ttt_if.illegal_move), 32'd1);
        chk("lit_turn_board", 32'(ttt_if.board), 32'h1);
`endif

        // randomized traffic, including back-to-back strobes and a mid-game reset
        for (int it = 0; it < 600; it++) begin
            if (it == 300) begin
                @(posedge clk); #1;
                drive(0, 0, 0, 0, 0);
                #2 reset = 1'b1;
                @(posedge clk); #3 reset = 1'b0;
            end
            @(posedge clk); #1;
            r   = int'($urandom_range(0, 99));
            ix  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
            ix2 = int'($urandom_range(0, 15));
            if (r < 3) begin
                drive(($urandom_range(0, 1) == 1), ix, 0, 0, 1);
            end else if (r < 7) begin
                drive(1, ix, 1, ix2, 0);
            end else if (r < 45) begin
                p2 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : (m_turn_p1 ? 0 : 1);
                if (p2 == 1) drive(0, 0, 1, ix, 0);
                else         drive(1, ix, 0, 0, 0);
            end else begin
                drive(0, 0, 0, 0, 0);
            end
        end
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0);
        gap(8);
        settle(1);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
